parity_serial_tx: RTL and testbench

- Serialises a WIDTH-bit word LSB-first, then appends one parity bit computed over the word.
- Transmit end of the team's even/odd and parity datapath; a downstream checker recomputes parity over the frame.
- Valid/ready word input, valid/ready bit-stream output.
- Frame length is WIDTH+1 accepted bits.

---
 rtl/parity_pkg.sv | 14 +
 rtl/parity_calc.sv | 15 +
 rtl/parity_serial_tx.sv | 94 +++++++++
 tb/tb_parity_serial_tx.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/parity_pkg.sv
// Shared definitions for the parity transmit/check datapath.
package parity_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2
  } tx_state_e;

  // Parity-sense selectors shared with the matching checker.
  localparam bit EVEN = 1'b0;
  localparam bit ODD  = 1'b1;

endpackage

// File: rtl/parity_calc.sv
// Reduction-XOR parity over a word with even/odd sense select.
module parity_calc
  import parity_pkg::*;
#(
  parameter int WIDTH      = 16,
  parameter bit ODD_PARITY = EVEN
) (
  input  logic [WIDTH-1:0] data_i,
  output logic             parity_o
);

  // Bit that makes the total ones count of {data, parity} even or odd.
  assign parity_o = (^data_i) ^ ODD_PARITY;

endmodule

// File: rtl/parity_serial_tx.sv
// Serialises a word LSB-first followed by one parity bit, valid/ready on both sides.
module parity_serial_tx
  import parity_pkg::*;
#(
  parameter int WIDTH      = 16,
  parameter bit ODD_PARITY = EVEN
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] data_in,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             tx_bit,
  output logic             tx_valid,
  input  logic             tx_ready,
  output logic             tx_last,
  output logic             busy
);

  localparam int             CW       = $clog2(WIDTH);
  localparam logic [CW-1:0]  LAST_IDX = CW'(WIDTH - 1);

  tx_state_e        state_q;
  logic [WIDTH-1:0] shift_q;
  logic [CW-1:0]    cnt_q;
  logic             par_q;
  logic             par_d;
  logic             accept;
  logic             xfer;

  parity_calc #(
    .WIDTH      (WIDTH),
    .ODD_PARITY (ODD_PARITY)
  ) u_calc (
    .data_i   (data_in),
    .parity_o (par_d)
  );

  // Ready during the parity beat only if that beat leaves this cycle, giving zero-bubble frames.
  assign in_ready = (state_q == IDLE) || ((state_q == PARITY) && tx_ready);
  assign accept   = in_valid && in_ready;
  assign xfer     = tx_valid && tx_ready;

  assign tx_valid = (state_q != IDLE);
  assign busy     = (state_q != IDLE);
  assign tx_last  = (state_q == PARITY);
  assign tx_bit   = (state_q == PARITY) ? par_q :
                    (state_q == DATA)   ? shift_q[0] : 1'b0;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      shift_q <= '0;
      cnt_q   <= '0;
      par_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            shift_q <= data_in;
            par_q   <= par_d;
            cnt_q   <= '0;
            state_q <= DATA;
          end
        end
        DATA: begin
          if (xfer) begin
            shift_q <= shift_q >> 1;
            if (cnt_q == LAST_IDX) begin
              cnt_q   <= '0;
              state_q <= PARITY;
            end else begin
              cnt_q <= cnt_q + CW'(1);
            end
          end
        end
        PARITY: begin
          if (xfer) begin
            if (accept) begin
              shift_q <= data_in;
              par_q   <= par_d;
              cnt_q   <= '0;
              state_q <= DATA;
            end else begin
              state_q <= IDLE;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_parity_serial_tx.sv
// Self-checking bench: an even and an odd instance driven in lockstep.
module tb_parity_serial_tx;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [W-1:0] data_in;
  logic         in_valid;
  logic         tx_ready;

  logic in_ready_e, tx_bit_e, tx_valid_e, tx_last_e, busy_e;
  logic in_ready_o, tx_bit_o, tx_valid_o, tx_last_o, busy_o;

  int tests_run    = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  parity_serial_tx #(.WIDTH(W), .ODD_PARITY(1'b0)) dut_even (
    .clk(clk), .rst_n(rst_n), .data_in(data_in), .in_valid(in_valid),
    .in_ready(in_ready_e), .tx_bit(tx_bit_e), .tx_valid(tx_valid_e),
    .tx_ready(tx_ready), .tx_last(tx_last_e), .busy(busy_e)
  );

  parity_serial_tx #(.WIDTH(W), .ODD_PARITY(1'b1)) dut_odd (
    .clk(clk), .rst_n(rst_n), .data_in(data_in), .in_valid(in_valid),
    .in_ready(in_ready_o), .tx_bit(tx_bit_o), .tx_valid(tx_valid_o),
    .tx_ready(tx_ready), .tx_last(tx_last_o), .busy(busy_o)
  );

  typedef struct {
    logic [W-1:0] word;
    logic         par_even;
    logic         par_odd;
  } vec_t;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic act, input logic exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  // Reference parity: count the ones and pick the bit that fixes the frame total.
  function automatic logic model_par(input logic [W-1:0] w, input logic odd);
    return logic'(($countones(w) % 2) != 0) ^ odd;
  endfunction

  // Accept one word, then transfer the whole frame, optionally stalling before bit stall_at.
  task automatic run_frame(input logic [W-1:0] w, input logic pe, input logic po,
                           input int stall_at, input int stall_len, input bit noise);
    logic eb_e, eb_o;
    data_in  = w;
    in_valid = 1'b1;
    tx_ready = 1'b1;
    chk("accept_in_ready", in_ready_e, 1'b1);
    step();
    in_valid = 1'b0;
    for (int k = 0; k <= W; k++) begin
      eb_e = (k < W) ? w[k] : pe;
      eb_o = (k < W) ? w[k] : po;
      if (k == stall_at) begin
        for (int s = 0; s < stall_len; s++) begin
          tx_ready = 1'b0;
          if (noise) begin
            in_valid = 1'($urandom_range(0, 1));
            data_in  = W'($urandom);
          end
          chk("stall_bit_held", tx_bit_e, eb_e);
          chk("stall_last_held", tx_last_e, (k == W));
          chk("stall_valid", tx_valid_e, 1'b1);
          chk("stall_in_ready", in_ready_e, 1'b0);
          step();
        end
      end
      tx_ready = 1'b1;
      if (noise && k < W) begin
        in_valid = 1'($urandom_range(0, 1));
        data_in  = W'($urandom);
      end else begin
        in_valid = 1'b0;
      end
      chk("bit_even", tx_bit_e, eb_e);
      chk("bit_odd", tx_bit_o, eb_o);
      chk("tx_last", tx_last_e, (k == W));
      chk("tx_valid", tx_valid_e, 1'b1);
      chk("busy", busy_e, 1'b1);
      chk("in_ready_frame", in_ready_e, (k == W));
      step();
    end
    in_valid = 1'b0;
    chk("end_valid", tx_valid_e, 1'b0);
    chk("end_busy", busy_e, 1'b0);
    chk("end_in_ready", in_ready_e, 1'b1);
    $display("[TB] frame %h parity e=%b o=%b stall@%0d x%0d", w, pe, po, stall_at, stall_len);
  endtask

  vec_t vecs[7];

  initial begin
    int vcount;
    logic [W-1:0] wd, rw;

    vecs[0] = '{16'h0001, 1'b1, 1'b0};
    vecs[1] = '{16'h0003, 1'b0, 1'b1};
    vecs[2] = '{16'hFFFF, 1'b0, 1'b1};
    vecs[3] = '{16'h0000, 1'b0, 1'b1};
    vecs[4] = '{16'hA5A5, 1'b0, 1'b1};
    vecs[5] = '{16'h1234, 1'b1, 1'b0};
    vecs[6] = '{16'h8000, 1'b1, 1'b0};

    rst_n = 1'b0; in_valid = 1'b0; tx_ready = 1'b0; data_in = '0;
    step(); step();
    chk("rst_tx_valid", tx_valid_e, 1'b0);
    chk("rst_tx_bit", tx_bit_e, 1'b0);
    chk("rst_tx_last", tx_last_e, 1'b0);
    chk("rst_busy", busy_e, 1'b0);
    chk("rst_in_ready", in_ready_e, 1'b1);
    chk("rst_odd_valid", tx_valid_o, 1'b0);
    rst_n = 1'b1;
    step();
    $display("[TB] reset checked");

    for (int i = 0; i < 7; i++) begin
      run_frame(vecs[i].word, vecs[i].par_even, vecs[i].par_odd, -1, 0, 1'b0);
    end

    // Backpressure: three stalled cycles while bit 4 of A5A5 (a 0) is presented.
    run_frame(16'hA5A5, 1'b0, 1'b1, 4, 3, 1'b0);

    // Back-to-back: second word accepted on the first frame's parity transfer.
    data_in = 16'h0001; in_valid = 1'b1; tx_ready = 1'b1;
    step();
    data_in = 16'h8000;
    vcount = 0;
    for (int f = 0; f < 2; f++) begin
      wd = (f == 0) ? 16'h0001 : 16'h8000;
      for (int k = 0; k <= W; k++) begin
        if (f == 1 && k == W) in_valid = 1'b0;
        if (tx_valid_e) vcount++;
        chk("b2b_valid", tx_valid_e, 1'b1);
        chk("b2b_bit_even", tx_bit_e, (k < W) ? wd[k] : 1'b1);
        chk("b2b_bit_odd", tx_bit_o, (k < W) ? wd[k] : 1'b0);
        chk("b2b_last", tx_last_e, (k == W));
        if (k == W) chk("b2b_in_ready", in_ready_e, 1'b1);
        step();
        if (f == 0 && k == W) in_valid = 1'b0;
      end
    end
    tests_run++;
    if (vcount != 34) begin
      tests_failed++;
      $display("FAIL b2b_contiguous: got %0d valid cycles expected 34", vcount);
    end
    chk("b2b_end_busy", busy_e, 1'b0);
    $display("[TB] back-to-back 0001/8000 valid cycles %0d", vcount);

    // Reset mid-frame after bit 7 of 1234.
    data_in = 16'h1234; in_valid = 1'b1; tx_ready = 1'b1;
    step();
    in_valid = 1'b0;
    wd = 16'h1234;
    for (int k = 0; k < 8; k++) begin
      chk("pre_rst_bit", tx_bit_e, wd[k]);
      step();
    end
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    chk("midrst_valid", tx_valid_e, 1'b0);
    chk("midrst_busy", busy_e, 1'b0);
    chk("midrst_in_ready", in_ready_e, 1'b1);
    chk("midrst_last", tx_last_e, 1'b0);
    $display("[TB] mid-frame reset checked");
    run_frame(16'h0002, 1'b1, 1'b0, -1, 0, 1'b0);

    // Randomised frames with stalls and ignored input noise, against the ones-count model.
    for (int i = 0; i < 20; i++) begin
      rw = W'($urandom);
      run_frame(rw, model_par(rw, 1'b0), model_par(rw, 1'b1),
                int'($urandom_range(0, W)), int'($urandom_range(0, 3)), 1'b1);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
